// File: rtl/proc_ctrl_if.sv
// Control/datapath connection for the TinyRV1 five-stage pipeline.
// The controller is the master: it drives c2d_* and inst_done_W, and samples d2c_*.
interface proc_ctrl_if;
  logic [31:0] d2c_inst;
  logic        d2c_eq_X;
  logic        c2d_imemreq_val;
  logic        c2d_reg_en_F;
  logic [1:0]  c2d_pc_sel_F;
  logic        c2d_reg_en_D;
  logic [1:0]  c2d_op1_byp_sel_D;
  logic [1:0]  c2d_op2_byp_sel_D;
  logic        c2d_op1_sel_D;
  logic        c2d_op2_sel_D;
  logic        c2d_alu_fn_X;
  logic        c2d_result_sel_X;
  logic        c2d_wb_sel_M;
  logic        c2d_rf_wen_W;
  logic [4:0]  c2d_rf_waddr_W;
  logic        inst_done_W;

  modport master (
    input  d2c_inst, d2c_eq_X,
    output c2d_imemreq_val, c2d_reg_en_F, c2d_pc_sel_F, c2d_reg_en_D,
           c2d_op1_byp_sel_D, c2d_op2_byp_sel_D, c2d_op1_sel_D, c2d_op2_sel_D,
           c2d_alu_fn_X, c2d_result_sel_X, c2d_wb_sel_M,
           c2d_rf_wen_W, c2d_rf_waddr_W, inst_done_W
  );

  modport slave (
    output d2c_inst, d2c_eq_X,
    input  c2d_imemreq_val, c2d_reg_en_F, c2d_pc_sel_F, c2d_reg_en_D,
           c2d_op1_byp_sel_D, c2d_op2_byp_sel_D, c2d_op1_sel_D, c2d_op2_sel_D,
           c2d_alu_fn_X, c2d_result_sel_X, c2d_wb_sel_M,
           c2d_rf_wen_W, c2d_rf_waddr_W, inst_done_W
  );
endinterface

// File: rtl/proc_ctrl.sv
// TinyRV1 pipeline control: decode in D, X/M/W control pipeline, bypass selects,
// jr-hazard stall, and jump/branch redirect with squash.
module proc_ctrl (
  input  logic        clk,
  input  logic        rst,
  proc_ctrl_if.master dp
);

  typedef enum logic [6:0] {
    OP_ADD  = 7'b0110011,
    OP_ADDI = 7'b0010011,
    OP_BNE  = 7'b1100011,
    OP_JAL  = 7'b1101111,
    OP_JALR = 7'b1100111
  } opcode_e;

  typedef enum logic [1:0] {PC_SEQ, PC_JAL, PC_BR, PC_JR} pc_sel_e;
  typedef enum logic [1:0] {BYP_RF, BYP_X, BYP_M, BYP_W} byp_sel_e;

  logic       val_D, val_X, val_M, val_W;
  logic       rf_wen_X, rf_wen_M, rf_wen_W;
  logic [4:0] waddr_X, waddr_M, waddr_W;
  logic       alu_fn_X, result_sel_X, is_bne_X;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd, rs1, rs2;
  logic       add_D, addi_D, bne_D, jal_D, jr_D;
  logic       wen_D, reads_rs1, reads_rs2;
  logic       stall_D, br_taken_X;

  always_comb begin
    opcode = dp.d2c_inst[6:0];
    rd     = dp.d2c_inst[11:7];
    funct3 = dp.d2c_inst[14:12];
    rs1    = dp.d2c_inst[19:15];
    rs2    = dp.d2c_inst[24:20];
    funct7 = dp.d2c_inst[31:25];

    // Anything not matched here (including the all-zero reset word) is a bubble.
    add_D  = val_D && opcode == OP_ADD  && funct3 == 3'b000 && funct7 == 7'b0000000;
    addi_D = val_D && opcode == OP_ADDI && funct3 == 3'b000;
    bne_D  = val_D && opcode == OP_BNE  && funct3 == 3'b001;
    jal_D  = val_D && opcode == OP_JAL;
    jr_D   = val_D && opcode == OP_JALR && funct3 == 3'b000 && rd == 5'd0 &&
             funct7 == 7'b0000000 && rs2 == 5'd0;

    wen_D     = (add_D || addi_D || jal_D) && rd != 5'd0;
    reads_rs1 = add_D || addi_D || bne_D || jr_D;
    reads_rs2 = add_D || bne_D;

    // jr needs its target in D; an X-stage producer is the one value not yet available.
    stall_D    = jr_D && val_X && rf_wen_X && waddr_X == rs1;
    br_taken_X = val_X && is_bne_X && !dp.d2c_eq_X;
  end

  function automatic byp_sel_e byp_sel(input logic [4:0] rs);
    if (rs == 5'd0)                               return BYP_RF;
    else if (val_X && rf_wen_X && waddr_X == rs)  return BYP_X;
    else if (val_M && rf_wen_M && waddr_M == rs)  return BYP_M;
    else if (val_W && rf_wen_W && waddr_W == rs)  return BYP_W;
    else                                          return BYP_RF;
  endfunction

  always_comb begin
    pc_sel_e pc_sel;
    if (rst || br_taken_X == 1'b0 && stall_D) pc_sel = PC_SEQ;
    else if (br_taken_X)                      pc_sel = PC_BR;
    else if (jal_D)                           pc_sel = PC_JAL;
    else if (jr_D)                            pc_sel = PC_JR;
    else                                      pc_sel = PC_SEQ;

    dp.c2d_imemreq_val   = !rst;
    dp.c2d_reg_en_F      = rst || br_taken_X || !stall_D;
    dp.c2d_reg_en_D      = rst || br_taken_X || !stall_D;
    dp.c2d_pc_sel_F      = pc_sel;
    dp.c2d_op1_byp_sel_D = (!rst && reads_rs1) ? byp_sel(rs1) : BYP_RF;
    dp.c2d_op2_byp_sel_D = (!rst && reads_rs2) ? byp_sel(rs2) : BYP_RF;
    dp.c2d_op1_sel_D     = !rst && jal_D;
    dp.c2d_op2_sel_D     = !rst && (addi_D || jal_D);
    dp.c2d_alu_fn_X      = !rst && alu_fn_X;
    dp.c2d_result_sel_X  = !rst && result_sel_X;
    dp.c2d_wb_sel_M      = 1'b0;
    dp.c2d_rf_wen_W      = !rst && val_W && rf_wen_W;
    dp.c2d_rf_waddr_W    = waddr_W;
    dp.inst_done_W       = !rst && val_W;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_D <= 1'b0;
      val_X <= 1'b0;
      val_M <= 1'b0;
      val_W <= 1'b0;
    end else begin
      val_M <= val_X;
      val_W <= val_M;
      // Branch squash wins over stall; a stall holds val_D and injects an X bubble.
      if (br_taken_X) begin
        val_D <= 1'b0;
        val_X <= 1'b0;
      end else if (stall_D) begin
        val_X <= 1'b0;
      end else begin
        val_X <= add_D || addi_D || bne_D || jal_D || jr_D;
        val_D <= !(jal_D || jr_D);
      end
    end
  end

  always_ff @(posedge clk) begin
    rf_wen_X     <= wen_D;
    waddr_X      <= rd;
    alu_fn_X     <= bne_D;
    result_sel_X <= jal_D;
    is_bne_X     <= bne_D;
    rf_wen_M     <= rf_wen_X;
    waddr_M      <= waddr_X;
    rf_wen_W     <= rf_wen_M;
    waddr_W      <= waddr_M;
  end

endmodule
